// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port A arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DBG  = 2'd2
    } owner_e;

    localparam logic [3:0] WE_READ    = 4'b0000;
    localparam int         WAIT_CNT_W = 8;

    function automatic logic is_read(input logic [3:0] we);
        return (we == WE_READ);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and BRAM port A signal bundle; the arbiter uses the slave view.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              cpu_req_i;
    logic [3:0]        cpu_we_i;
    logic [31:0]       cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic              cpu_gnt_o;
    logic              cpu_rvalid_o;
    logic [DATA_W-1:0] cpu_rdata_o;

    logic              dbg_req_i;
    logic [3:0]        dbg_we_i;
    logic [31:0]       dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_gnt_o;
    logic              dbg_rvalid_o;
    logic [DATA_W-1:0] dbg_rdata_o;

    logic              mem_en_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              dbg_starved_o;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output dbg_starved_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  dbg_starved_o
    );

endinterface

// File: rtl/starvation_counter.sv
// Counts consecutive denied debug cycles, saturating at MAX_WAIT; force_gnt
// asks the arbiter to override the CPU once the limit is reached.
module starvation_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic force_gnt
);
    localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] cnt_r;
    logic [WAIT_CNT_W-1:0] cnt_next_s;

    // Next count: clear on grant or idle, otherwise climb to the limit.
    always_comb begin
        cnt_next_s = cnt_r;
        if (!req || gnt) begin
            cnt_next_s = {WAIT_CNT_W{1'b0}};
        end else if (cnt_r >= MAX_CNT) begin
            cnt_next_s = MAX_CNT;
        end else begin
            cnt_next_s = cnt_r + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {WAIT_CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign force_gnt = (cnt_r == MAX_CNT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares data-memory BRAM port A between the CPU (default priority) and a debug
// master, converting byte to word addresses and steering 1-cycle read data back.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input logic                clk,
    input logic                reset,
    dmem_port_arbiter_if.slave bus
);
    logic              force_gnt_s;
    logic              cpu_gnt_s;
    logic              dbg_gnt_s;
    owner_e            rd_owner_r;
    owner_e            rd_owner_next_s;
    logic              starved_r;
    logic [DATA_W-1:0] cpu_rdata_s;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] dbg_rdata_s;
    logic [DATA_W-1:0] dbg_rdata_r;
    logic              unused_addr_bits_s;

    starvation_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.dbg_req_i),
        .gnt       (dbg_gnt_s),
        .force_gnt (force_gnt_s)
    );

    // Same-cycle grant: CPU wins unless the debug master has waited too long.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dbg_gnt_s = 1'b0;
        if (reset) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else begin
            dbg_gnt_s = bus.dbg_req_i & (~bus.cpu_req_i | force_gnt_s);
            cpu_gnt_s = bus.cpu_req_i & ~dbg_gnt_s;
        end
    end

    // BRAM drive from the granted requester and next read owner.
    always_comb begin
        bus.mem_we_o    = 4'b0000;
        bus.mem_addr_o  = {ADDR_W{1'b0}};
        bus.mem_wdata_o = {DATA_W{1'b0}};
        rd_owner_next_s = OWNER_NONE;
        case ({cpu_gnt_s, dbg_gnt_s})
            2'b10: begin
                bus.mem_we_o    = bus.cpu_we_i;
                bus.mem_addr_o  = bus.cpu_addr_i[ADDR_W+1:2];
                bus.mem_wdata_o = bus.cpu_wdata_i;
                rd_owner_next_s = is_read(bus.cpu_we_i) ? OWNER_CPU : OWNER_NONE;
            end
            2'b01: begin
                bus.mem_we_o    = bus.dbg_we_i;
                bus.mem_addr_o  = bus.dbg_addr_i[ADDR_W+1:2];
                bus.mem_wdata_o = bus.dbg_wdata_i;
                rd_owner_next_s = is_read(bus.dbg_we_i) ? OWNER_DBG : OWNER_NONE;
            end
            default: begin
                bus.mem_we_o    = 4'b0000;
                bus.mem_addr_o  = {ADDR_W{1'b0}};
                bus.mem_wdata_o = {DATA_W{1'b0}};
                rd_owner_next_s = OWNER_NONE;
            end
        endcase
    end

    // The read owner sees BRAM data live; the other side keeps its last word.
    always_comb begin
        cpu_rdata_s = cpu_rdata_r;
        dbg_rdata_s = dbg_rdata_r;
        case (rd_owner_r)
            OWNER_CPU: cpu_rdata_s = bus.mem_rdata_i;
            OWNER_DBG: dbg_rdata_s = bus.mem_rdata_i;
            default: begin
                cpu_rdata_s = cpu_rdata_r;
                dbg_rdata_s = dbg_rdata_r;
            end
        endcase
    end

    // Read tracking, held read data and the starvation pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_owner_r  <= OWNER_NONE;
            starved_r   <= 1'b0;
            cpu_rdata_r <= {DATA_W{1'b0}};
            dbg_rdata_r <= {DATA_W{1'b0}};
        end else begin
            rd_owner_r  <= rd_owner_next_s;
            starved_r   <= dbg_gnt_s & force_gnt_s & bus.cpu_req_i;
            cpu_rdata_r <= cpu_rdata_s;
            dbg_rdata_r <= dbg_rdata_s;
        end
    end

    assign bus.cpu_gnt_o     = cpu_gnt_s;
    assign bus.dbg_gnt_o     = dbg_gnt_s;
    assign bus.mem_en_o      = cpu_gnt_s | dbg_gnt_s;
    assign bus.cpu_rvalid_o  = (rd_owner_r == OWNER_CPU);
    assign bus.dbg_rvalid_o  = (rd_owner_r == OWNER_DBG);
    assign bus.cpu_rdata_o   = cpu_rdata_s;
    assign bus.dbg_rdata_o   = dbg_rdata_s;
    assign bus.dbg_starved_o = starved_r;

    // Byte-lane and out-of-range address bits carry no meaning for a word BRAM.
    assign unused_addr_bits_s = ^{bus.cpu_addr_i[1:0], bus.cpu_addr_i[31:ADDR_W+2],
                                  bus.dbg_addr_i[1:0], bus.dbg_addr_i[31:ADDR_W+2]};

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed plus randomized bench for dmem_port_arbiter against a word-level
// memory model and the arbitration rules, with a 1-cycle-latency BRAM stand-in.
module tb_dmem_port_arbiter;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 8;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM port A stand-in: registered read, byte-lane write.
    logic [31:0] bram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            bus.mem_rdata_i <= bram[bus.mem_addr_o];
            for (int l = 0; l < 4; l++) begin
                if (bus.mem_we_o[l]) bram[bus.mem_addr_o][8*l +: 8] <= bus.mem_wdata_o[8*l +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] model_mem [int];
    int          streak;
    int          pend_owner;
    logic [31:0] pend_data;
    bit          starve_pend;
    logic [31:0] exp_cpu_rdata;
    logic [31:0] exp_dbg_rdata;
    bit          last_cgnt, last_dgnt;
    logic        obs_cgnt, obs_dgnt, obs_starved;

    // Random-phase requester state
    logic        c_req, d_req;
    logic [3:0]  c_we, d_we;
    logic [31:0] c_addr, d_addr, c_wd, d_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w = word_of(a);
        return model_mem.exists(w) ? model_mem[w] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        logic [31:0] cur;
        cur = model_read(a);
        for (int l = 0; l < 4; l++) begin
            if (we[l]) cur[8*l +: 8] = d[8*l +: 8];
        end
        model_mem[word_of(a)] = cur;
    endtask

    // One clock: drive, check at the falling edge, then advance the model.
    task automatic cycle(input logic rst, input logic creq, input logic [3:0] cwe,
                         input logic [31:0] caddr, input logic [31:0] cwd,
                         input logic dreq, input logic [3:0] dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd);
        bit          eg_c, eg_d;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_wd;
        reset           = rst;
        bus.cpu_req_i   = creq;
        bus.cpu_we_i    = cwe;
        bus.cpu_addr_i  = caddr;
        bus.cpu_wdata_i = cwd;
        bus.dbg_req_i   = dreq;
        bus.dbg_we_i    = dwe;
        bus.dbg_addr_i  = daddr;
        bus.dbg_wdata_i = dwd;
        @(negedge clk);
        if (rst) begin
            eg_c = 1'b0;
            eg_d = 1'b0;
            exp_cpu_rdata = 32'h0;
            exp_dbg_rdata = 32'h0;
        end else begin
            eg_d = dreq && (!creq || streak >= MAX_WAIT);
            eg_c = creq && !eg_d;
            if (pend_owner == 1) exp_cpu_rdata = pend_data;
            if (pend_owner == 2) exp_dbg_rdata = pend_data;
        end
        e_we   = eg_c ? cwe : (eg_d ? dwe : 4'h0);
        e_addr = eg_c ? 32'(caddr[ADDR_W+1:2]) : (eg_d ? 32'(daddr[ADDR_W+1:2]) : 32'h0);
        e_wd   = eg_c ? cwd : dwd;
        obs_cgnt    = bus.cpu_gnt_o;
        obs_dgnt    = bus.dbg_gnt_o;
        obs_starved = bus.dbg_starved_o;
        chk("cpu_gnt", 32'(bus.cpu_gnt_o), 32'(eg_c));
        chk("dbg_gnt", 32'(bus.dbg_gnt_o), 32'(eg_d));
        chk("mem_en", 32'(bus.mem_en_o), 32'(eg_c | eg_d));
        chk("mem_we", 32'(bus.mem_we_o), 32'(e_we));
        chk("mem_addr", 32'(bus.mem_addr_o), e_addr);
        if (eg_c || eg_d) chk("mem_wdata", bus.mem_wdata_o, e_wd);
        chk("cpu_rvalid", 32'(bus.cpu_rvalid_o), 32'(!rst && pend_owner == 1));
        chk("dbg_rvalid", 32'(bus.dbg_rvalid_o), 32'(!rst && pend_owner == 2));
        chk("cpu_rdata", bus.cpu_rdata_o, exp_cpu_rdata);
        chk("dbg_rdata", bus.dbg_rdata_o, exp_dbg_rdata);
        chk("dbg_starved", 32'(bus.dbg_starved_o), 32'(!rst && starve_pend));
        @(posedge clk);
        #1;
        if (rst) begin
            streak      = 0;
            pend_owner  = 0;
            starve_pend = 1'b0;
        end else begin
            starve_pend = eg_d && creq;
            if (dreq && !eg_d) streak = (streak + 1 > MAX_WAIT) ? MAX_WAIT : streak + 1;
            else streak = 0;
            pend_owner = 0;
            if (eg_c) begin
                if (cwe == 4'h0) begin pend_owner = 1; pend_data = model_read(caddr); end
                else model_write(caddr, cwe, cwd);
            end else if (eg_d) begin
                if (dwe == 4'h0) begin pend_owner = 2; pend_data = model_read(daddr); end
                else model_write(daddr, dwe, dwd);
            end
        end
        last_cgnt = eg_c;
        last_dgnt = eg_d;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] mk_addr();
        return {15'($urandom), 11'h000, 4'($urandom_range(0, 15)), 2'($urandom)};
    endfunction

    initial begin
        streak = 0; pend_owner = 0; pend_data = 32'h0; starve_pend = 1'b0;
        exp_cpu_rdata = 32'h0; exp_dbg_rdata = 32'h0;
        last_cgnt = 1'b0; last_dgnt = 1'b0;
        reset = 1'b1;

        // Reset held with both requesters active
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b1, 4'hF, 32'h0, 32'h1111_1111, 1'b1, 4'hF, 32'h4, 32'h2222_2222);
        cycle(1'b0, 1'b1, 4'hF, 32'h0, 32'h1111_1111, 1'b1, 4'hF, 32'h4, 32'h2222_2222);
        chk("first_after_reset_cpu", 32'(obs_cgnt), 32'h1);
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h4, 32'h2222_2222);

        // Fill words 0..15 through the debug port
        for (int w = 0; w < 16; w++)
            cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'(w * 4), $urandom);

        // Debug write then CPU read of 0xDEADBEEF at byte 0x10
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        cycle(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        chk("cpu_read_deadbeef", bus.cpu_rdata_o, 32'hDEAD_BEEF);

        // Collision: CPU half-word write beats a debug read
        cycle(1'b0, 1'b1, 4'b0011, 32'h20, 32'hA5A5_5A5A, 1'b1, 4'h0, 32'h24, 32'h0);
        chk("collision_wait_cnt", 32'(dut.u_starve.cnt_r), 32'(streak));
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h24, 32'h0);
        idle();

        // Starvation: continuous CPU reads, debug read forced on the 9th cycle
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b0, 1'b1, 4'h0, 32'h8, 32'h0, 1'b1, 4'h0, 32'h14, 32'h0);
            if (i == 9) begin
                chk("starve_dbg_gnt", 32'(obs_dgnt), 32'h1);
                chk("starve_cpu_gnt", 32'(obs_cgnt), 32'h0);
            end
        end
        cycle(1'b0, 1'b1, 4'h0, 32'h8, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("starve_pulse", 32'(obs_starved), 32'h1);
        chk("starve_wait_cnt", 32'(dut.u_starve.cnt_r), 32'h0);
        idle();

        // Interleaved reads from alternating owners
        cycle(1'b0, 1'b1, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h4, 32'h0);
        idle();
        idle();

        // Reset in the cycle after a debug read grant
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
        cycle(1'b1, 1'b1, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
        cycle(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        idle();

        // Randomized traffic; each requester holds its request until granted
        c_req = 1'b0; d_req = 1'b0;
        c_we = 4'h0; d_we = 4'h0; c_addr = 32'h0; d_addr = 32'h0; c_wd = 32'h0; d_wd = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (!c_req || last_cgnt) begin
                c_req  = ($urandom_range(0, 3) != 0);
                c_we   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                c_addr = mk_addr();
                c_wd   = $urandom;
            end
            if (!d_req || last_dgnt) begin
                d_req  = ($urandom_range(0, 1) != 0);
                d_we   = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
                d_addr = mk_addr();
                d_wd   = $urandom;
            end
            cycle(1'b0, c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
